// File: rtl/saturn_rstk_arbiter.sv
// Saturn 8-entry return stack with a fixed-priority arbiter for jump, RTN, exec-unit and debugger access.
// After reset every entry is cleared, one per enabled cycle, before any request is granted.
module saturn_rstk_arbiter #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 20,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clk_en,
    input  logic             i_jmp_push_req,
    input  logic [WIDTH-1:0] i_jmp_push_data,
    output logic             o_jmp_push_ack,
    input  logic             i_rtn_pop_req,
    output logic             o_rtn_pop_ack,
    output logic [WIDTH-1:0] o_rtn_pop_data,
    input  logic             i_exu_req,
    input  logic             i_exu_push,
    input  logic [WIDTH-1:0] i_exu_data,
    output logic             o_exu_ack,
    output logic [WIDTH-1:0] o_exu_data,
    input  logic             i_dbg_req,
    input  logic [PTR_W-1:0] i_dbg_idx,
    output logic             o_dbg_ack,
    output logic [WIDTH-1:0] o_dbg_data,
    output logic             o_busy,
    output logic [PTR_W-1:0] o_ptr,
    output logic [PTR_W:0]   o_depth
);

    typedef enum logic {INIT, IDLE} state_t;

    localparam logic [PTR_W-1:0] ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   DONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FULL = (PTR_W + 1)'(DEPTH);

    state_t           state, state_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr, init_cnt, ptr_inc, ptr_dec;
    logic [PTR_W:0]   depth;
    logic             grant_jmp, grant_rtn, grant_exu, grant_dbg;
    logic             do_push, do_pop, empty, init_step;
    logic [WIDTH-1:0] push_data, pop_val, dbg_val;

    assign ptr_inc   = ptr + ONE;
    assign ptr_dec   = ptr - ONE;
    assign empty     = (depth == '0);
    assign init_step = (state == INIT) && i_clk_en;
    assign do_push   = grant_jmp | (grant_exu & i_exu_push);
    assign do_pop    = grant_rtn | (grant_exu & ~i_exu_push);
    assign push_data = grant_jmp ? i_jmp_push_data : i_exu_data;
    assign pop_val   = empty ? '0 : mem[ptr];
    assign dbg_val   = mem[ptr - i_dbg_idx];

    assign o_busy  = (state == INIT);
    assign o_ptr   = ptr;
    assign o_depth = depth;

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= INIT;
        else         state <= state_next;
    end

    // A requester whose ack is currently high is skipped so a held level request is not granted twice.
    always_comb begin
        state_next = state;
        grant_jmp  = 1'b0;
        grant_rtn  = 1'b0;
        grant_exu  = 1'b0;
        grant_dbg  = 1'b0;
        case (state)
            INIT: if (i_clk_en && init_cnt == LAST) state_next = IDLE;
            IDLE: begin
                if (i_clk_en) begin
                    if (i_jmp_push_req && !o_jmp_push_ack)  grant_jmp = 1'b1;
                    else if (i_rtn_pop_req && !o_rtn_pop_ack) grant_rtn = 1'b1;
                    else if (i_exu_req && !o_exu_ack)       grant_exu = 1'b1;
                    else if (i_dbg_req && !o_dbg_ack)       grant_dbg = 1'b1;
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (init_step)              mem[init_cnt] <= '0;
            else if (do_push)           mem[ptr_inc]  <= push_data;
            else if (do_pop && !empty)  mem[ptr]      <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ptr            <= '1;
            depth          <= '0;
            init_cnt       <= '0;
            o_jmp_push_ack <= 1'b0;
            o_rtn_pop_ack  <= 1'b0;
            o_exu_ack      <= 1'b0;
            o_dbg_ack      <= 1'b0;
            o_rtn_pop_data <= '0;
            o_exu_data     <= '0;
            o_dbg_data     <= '0;
        end else begin
            o_jmp_push_ack <= grant_jmp;
            o_rtn_pop_ack  <= grant_rtn;
            o_exu_ack      <= grant_exu;
            o_dbg_ack      <= grant_dbg;
            if (init_step) init_cnt <= init_cnt + ONE;
            // Pushing onto a full stack wraps over the oldest entry; depth stays saturated.
            if (do_push) begin
                ptr <= ptr_inc;
                if (depth != FULL) depth <= depth + DONE;
            end
            if (do_pop && !empty) begin
                ptr   <= ptr_dec;
                depth <= depth - DONE;
            end
            if (grant_rtn)                o_rtn_pop_data <= pop_val;
            if (grant_exu && !i_exu_push) o_exu_data     <= pop_val;
            if (grant_dbg)                o_dbg_data     <= dbg_val;
        end
    end

endmodule

// File: tb/tb_saturn_rstk_arbiter.sv
// Directed self-checking bench for saturn_rstk_arbiter: init sweep, push/pop order, arbitration,
// wraparound, empty pops, clock enable and reset recovery.
module tb_saturn_rstk_arbiter;

    logic        clk = 1'b0;
    logic        reset, clk_en;
    logic        jmp_req, jmp_ack;
    logic [19:0] jmp_data;
    logic        rtn_req, rtn_ack;
    logic [19:0] rtn_data;
    logic        exu_req, exu_push, exu_ack;
    logic [19:0] exu_din, exu_dout;
    logic        dbg_req, dbg_ack;
    logic [2:0]  dbg_idx;
    logic [19:0] dbg_data;
    logic        busy;
    logic [2:0]  ptr;
    logic [3:0]  depth;

    int checks   = 0;
    int failures = 0;

    saturn_rstk_arbiter #(.DEPTH(8), .WIDTH(20)) dut (
        .i_clk(clk), .i_reset(reset), .i_clk_en(clk_en),
        .i_jmp_push_req(jmp_req), .i_jmp_push_data(jmp_data), .o_jmp_push_ack(jmp_ack),
        .i_rtn_pop_req(rtn_req), .o_rtn_pop_ack(rtn_ack), .o_rtn_pop_data(rtn_data),
        .i_exu_req(exu_req), .i_exu_push(exu_push), .i_exu_data(exu_din),
        .o_exu_ack(exu_ack), .o_exu_data(exu_dout),
        .i_dbg_req(dbg_req), .i_dbg_idx(dbg_idx), .o_dbg_ack(dbg_ack), .o_dbg_data(dbg_data),
        .o_busy(busy), .o_ptr(ptr), .o_depth(depth)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_jmp(input logic [19:0] d, input int exp_depth, input int exp_ptr);
        jmp_req = 1'b1; jmp_data = d;
        step();
        chk("jmp_ack", 32'(jmp_ack), 1);
        chk("push_depth", 32'(depth), 32'(exp_depth));
        chk("push_ptr", 32'(ptr), 32'(exp_ptr));
        jmp_req = 1'b0;
        step();
        chk("jmp_ack_drop", 32'(jmp_ack), 0);
    endtask

    task automatic pop_rtn(input logic [19:0] exp_d, input int exp_depth, input int exp_ptr);
        rtn_req = 1'b1;
        step();
        chk("rtn_ack", 32'(rtn_ack), 1);
        chk("rtn_data", 32'(rtn_data), 32'(exp_d));
        chk("pop_depth", 32'(depth), 32'(exp_depth));
        chk("pop_ptr", 32'(ptr), 32'(exp_ptr));
        rtn_req = 1'b0;
        step();
        chk("rtn_ack_drop", 32'(rtn_ack), 0);
    endtask

    task automatic dbg_rd(input int idx, input logic [19:0] exp_d);
        dbg_req = 1'b1; dbg_idx = 3'(idx);
        step();
        chk("dbg_ack", 32'(dbg_ack), 1);
        chk("dbg_data", 32'(dbg_data), 32'(exp_d));
        dbg_req = 1'b0;
        step();
    endtask

    task automatic init_sweep();
        for (int i = 0; i < 8; i++) begin
            chk("init_busy", 32'(busy), 1);
            chk("init_no_ack", 32'({jmp_ack, rtn_ack, exu_ack, dbg_ack}), 0);
            if (i == 7) begin
                dbg_req = 1'b0;
                jmp_req = 1'b0;
            end
            step();
        end
        chk("busy_done", 32'(busy), 0);
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b1;
        jmp_req = 1'b0; jmp_data = '0; rtn_req = 1'b0;
        exu_req = 1'b0; exu_push = 1'b0; exu_din = '0;
        dbg_req = 1'b0; dbg_idx = '0;
        step(); step();
        chk("rst_busy", 32'(busy), 1);
        chk("rst_ptr", 32'(ptr), 7);
        chk("rst_depth", 32'(depth), 0);
        chk("rst_acks", 32'({jmp_ack, rtn_ack, exu_ack, dbg_ack}), 0);
        chk("rst_data", 32'(rtn_data | exu_dout | dbg_data), 0);

        // requests during INIT are ignored
        reset = 1'b0;
        dbg_req = 1'b1;
        init_sweep();
        for (int i = 0; i < 8; i++) dbg_rd(i, 20'h00000);

        push_jmp(20'h12345, 1, 0);
        push_jmp(20'h23456, 2, 1);
        pop_rtn(20'h23456, 1, 0);
        pop_rtn(20'h12345, 0, 7);

        // all four requesters at once
        jmp_req = 1'b1; jmp_data = 20'hABCDE; rtn_req = 1'b1;
        exu_req = 1'b1; exu_push = 1'b0; dbg_req = 1'b1; dbg_idx = 3'd0;
        step();
        chk("arb1_acks", 32'({jmp_ack, rtn_ack, exu_ack, dbg_ack}), 32'b1000);
        chk("arb1_depth", 32'(depth), 1);
        jmp_req = 1'b0;
        step();
        chk("arb2_acks", 32'({jmp_ack, rtn_ack, exu_ack, dbg_ack}), 32'b0100);
        chk("arb2_data", 32'(rtn_data), 32'h0ABCDE);
        rtn_req = 1'b0;
        step();
        chk("arb3_acks", 32'({jmp_ack, rtn_ack, exu_ack, dbg_ack}), 32'b0010);
        chk("arb3_data", 32'(exu_dout), 0);
        chk("arb3_ptr", 32'(ptr), 7);
        exu_req = 1'b0;
        step();
        chk("arb4_acks", 32'({jmp_ack, rtn_ack, exu_ack, dbg_ack}), 32'b0001);
        chk("arb4_data", 32'(dbg_data), 0);
        dbg_req = 1'b0;
        step();
        chk("arb5_acks", 32'({jmp_ack, rtn_ack, exu_ack, dbg_ack}), 0);

        // exec unit push then pop; exu data holds across a push ack
        exu_req = 1'b1; exu_push = 1'b1; exu_din = 20'h55555;
        step();
        chk("exu_push_ack", 32'(exu_ack), 1);
        chk("exu_push_hold", 32'(exu_dout), 0);
        chk("exu_push_depth", 32'(depth), 1);
        exu_req = 1'b0;
        step();
        exu_req = 1'b1; exu_push = 1'b0;
        step();
        chk("exu_pop_ack", 32'(exu_ack), 1);
        chk("exu_pop_data", 32'(exu_dout), 32'h55555);
        chk("exu_pop_depth", 32'(depth), 0);
        exu_req = 1'b0;
        step();

        // wraparound: nine pushes onto an eight-entry stack
        for (int v = 1; v <= 9; v++) push_jmp(20'(v), (v > 8) ? 8 : v, (v - 1) % 8);
        dbg_rd(0, 20'h9);
        dbg_rd(7, 20'h2);
        for (int k = 1; k <= 8; k++) pop_rtn(20'(10 - k), 8 - k, (8 - k) % 8);
        pop_rtn(20'h0, 0, 0);

        // clock enable gating; an ack still drops while enable is low
        jmp_req = 1'b1; jmp_data = 20'h77777;
        step();
        chk("en_ack", 32'(jmp_ack), 1);
        clk_en = 1'b0;
        step();
        chk("en_ack_drop", 32'(jmp_ack), 0);
        step();
        chk("en_hold_ack", 32'(jmp_ack), 0);
        chk("en_hold_depth", 32'(depth), 1);
        jmp_req = 1'b0; rtn_req = 1'b1;
        step(); step();
        chk("en_rtn_blocked", 32'(rtn_ack), 0);
        chk("en_rtn_depth", 32'(depth), 1);
        clk_en = 1'b1;
        step();
        chk("en_rtn_ack", 32'(rtn_ack), 1);
        chk("en_rtn_data", 32'(rtn_data), 32'h77777);
        rtn_req = 1'b0;
        step();

        // reset after pushes, then again part-way through INIT
        push_jmp(20'h13579, 1, 1);
        jmp_req = 1'b1; jmp_data = 20'h2468A; reset = 1'b1;
        step();
        chk("rr_ack", 32'(jmp_ack), 0);
        chk("rr_busy", 32'(busy), 1);
        chk("rr_depth", 32'(depth), 0);
        chk("rr_ptr", 32'(ptr), 7);
        jmp_req = 1'b0; reset = 1'b0;
        step(); step(); step();
        chk("ri_busy", 32'(busy), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        init_sweep();
        dbg_rd(6, 20'h0);
        chk("rr_depth_after", 32'(depth), 0);

        // pop on empty stack after reinit
        pop_rtn(20'h0, 0, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
